// File: rtl/decode.sv
// decode: second stage of the 16-bit CPU pipeline.
// Merges two-word instructions with their immediate, resolves JMP/BRA locally
// by redirecting fetch, and drops words whose address is off the current path.
module decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [15:0] fetch_addr_i,
  input  logic [15:0] fetch_inst_i,
  output logic        fetch_valid_o,
  output logic [15:0] fetch_pc_o,
  output logic        exe_valid_o,
  input  logic        exe_ready_i,
  output logic [15:0] exe_addr_o,
  output logic [3:0]  exe_opcode_o,
  output logic [3:0]  exe_dst_o,
  output logic [3:0]  exe_src_o,
  output logic        exe_imm_valid_o,
  output logic [15:0] exe_imm_o
);

  typedef enum logic {OPC, IMM} state_t;

  localparam logic [3:0] OP_BRA = 4'hE;
  localparam logic [3:0] OP_JMP = 4'hF;

  state_t      state;
  logic [15:0] expected_pc;
  logic [15:0] held_inst;
  logic [15:0] held_addr;

  logic        accept;
  logic        keep;
  logic        is_bra;
  logic        imm_flag;
  logic        held_jmp;
  logic [15:0] next_pc;
  logic [15:0] bra_target;

  // Accept whenever the output register is free or is being drained this cycle.
  assign fetch_ready_o = !exe_valid_o || exe_ready_i;
  assign accept        = fetch_valid_i && fetch_ready_o;
  // Words from an abandoned path carry the wrong address and are ignored.
  assign keep          = accept && (fetch_addr_i == expected_pc);
  assign is_bra        = fetch_inst_i[15:12] == OP_BRA;
  assign imm_flag      = fetch_inst_i[3];
  assign held_jmp      = held_inst[15:12] == OP_JMP;
  assign next_pc       = fetch_addr_i + 16'd1;
  assign bra_target    = fetch_addr_i + 16'd1 + {{8{fetch_inst_i[7]}}, fetch_inst_i[7:0]};

  // Opcode/immediate state machine with registered fetch-redirect and execute outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state           <= OPC;
      expected_pc     <= RESET_PC;
      held_inst       <= '0;
      held_addr       <= '0;
      fetch_valid_o   <= 1'b1;
      fetch_pc_o      <= RESET_PC;
      exe_valid_o     <= 1'b0;
      exe_addr_o      <= '0;
      exe_opcode_o    <= '0;
      exe_dst_o       <= '0;
      exe_src_o       <= '0;
      exe_imm_valid_o <= 1'b0;
      exe_imm_o       <= '0;
    end else begin
      fetch_valid_o <= 1'b0;
      if (exe_valid_o && exe_ready_i) exe_valid_o <= 1'b0;
      if (keep) begin
        expected_pc <= next_pc;
        case (state)
          OPC: begin
            if (is_bra) begin
              fetch_valid_o <= 1'b1;
              fetch_pc_o    <= bra_target;
              expected_pc   <= bra_target;
            end else if (imm_flag) begin
              held_inst <= fetch_inst_i;
              held_addr <= fetch_addr_i;
              state     <= IMM;
            end else begin
              exe_valid_o     <= 1'b1;
              exe_addr_o      <= fetch_addr_i;
              exe_opcode_o    <= fetch_inst_i[15:12];
              exe_dst_o       <= fetch_inst_i[11:8];
              exe_src_o       <= fetch_inst_i[7:4];
              exe_imm_valid_o <= 1'b0;
              exe_imm_o       <= '0;
            end
          end
          IMM: begin
            state <= OPC;
            if (held_jmp) begin
              fetch_valid_o <= 1'b1;
              fetch_pc_o    <= fetch_inst_i;
              expected_pc   <= fetch_inst_i;
            end else begin
              exe_valid_o     <= 1'b1;
              exe_addr_o      <= held_addr;
              exe_opcode_o    <= held_inst[15:12];
              exe_dst_o       <= held_inst[11:8];
              exe_src_o       <= held_inst[7:4];
              exe_imm_valid_o <= 1'b1;
              exe_imm_o       <= fetch_inst_i;
            end
          end
          default: state <= OPC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: reset, plain/immediate words, BRA, JMP across
// the address wrap, stale-word drop, execute back-pressure, reset mid-IMM.
module tb_decode;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [15:0] fetch_addr_i;
  logic [15:0] fetch_inst_i;
  logic        fetch_valid_o;
  logic [15:0] fetch_pc_o;
  logic        exe_valid_o;
  logic        exe_ready_i;
  logic [15:0] exe_addr_o;
  logic [3:0]  exe_opcode_o;
  logic [3:0]  exe_dst_o;
  logic [3:0]  exe_src_o;
  logic        exe_imm_valid_o;
  logic [15:0] exe_imm_o;

  int checks = 0;
  int errors = 0;

  decode #(.RESET_PC(16'h0100)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_addr_i(fetch_addr_i), .fetch_inst_i(fetch_inst_i),
    .fetch_valid_o(fetch_valid_o), .fetch_pc_o(fetch_pc_o),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i),
    .exe_addr_o(exe_addr_o), .exe_opcode_o(exe_opcode_o),
    .exe_dst_o(exe_dst_o), .exe_src_o(exe_src_o),
    .exe_imm_valid_o(exe_imm_valid_o), .exe_imm_o(exe_imm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] w);
    fetch_valid_i = v;
    fetch_addr_i  = a;
    fetch_inst_i  = w;
  endtask

  task automatic chk_exe(input string tag, input logic [15:0] a, input logic [3:0] op,
                         input logic [3:0] d, input logic [3:0] s,
                         input logic iv, input logic [15:0] im);
    chk({tag, ".valid"}, {15'd0, exe_valid_o}, 16'd1);
    chk({tag, ".addr"}, exe_addr_o, a);
    chk({tag, ".op"}, {12'd0, exe_opcode_o}, {12'd0, op});
    chk({tag, ".dst"}, {12'd0, exe_dst_o}, {12'd0, d});
    chk({tag, ".src"}, {12'd0, exe_src_o}, {12'd0, s});
    chk({tag, ".immv"}, {15'd0, exe_imm_valid_o}, {15'd0, iv});
    chk({tag, ".imm"}, exe_imm_o, im);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".fv"}, {15'd0, fetch_valid_o}, 16'd1);
    chk({tag, ".fpc"}, fetch_pc_o, 16'h0100);
    chk({tag, ".ev"}, {15'd0, exe_valid_o}, 16'd0);
    chk({tag, ".eaddr"}, exe_addr_o, 16'h0000);
    chk({tag, ".eop"}, {12'd0, exe_opcode_o}, 16'd0);
    chk({tag, ".edst"}, {12'd0, exe_dst_o}, 16'd0);
    chk({tag, ".esrc"}, {12'd0, exe_src_o}, 16'd0);
    chk({tag, ".eimmv"}, {15'd0, exe_imm_valid_o}, 16'd0);
    chk({tag, ".eimm"}, exe_imm_o, 16'h0000);
    chk({tag, ".frdy"}, {15'd0, fetch_ready_o}, 16'd1);
  endtask

  initial begin
    rstn = 1'b0;
    exe_ready_i = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    tick(); tick();
    chk_reset_state("rst");

    // Release reset and present the first word in the first cycle after reset.
    rstn = 1'b1;
    chk("rel.fv", {15'd0, fetch_valid_o}, 16'd1);
    drive(1'b1, 16'h0100, 16'h1230);
    tick();
    chk("rel.fv_drop", {15'd0, fetch_valid_o}, 16'd0);
    chk_exe("w1", 16'h0100, 4'h1, 4'h2, 4'h3, 1'b0, 16'h0000);
    drive(1'b1, 16'h0101, 16'h4560);
    tick();
    chk_exe("w2", 16'h0101, 4'h4, 4'h5, 4'h6, 1'b0, 16'h0000);
    drive(1'b0, 16'h0, 16'h0);
    tick();
    chk("idle.ev", {15'd0, exe_valid_o}, 16'd0);

    // Reset again; two-word instruction from RESET_PC.
    rstn = 1'b0;
    tick(); tick();
    chk_reset_state("rst2");
    rstn = 1'b1;
    drive(1'b1, 16'h0100, 16'h2238);
    tick();
    chk("imm1.ev", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h0101, 16'hBEEF);
    tick();
    chk_exe("imm", 16'h0100, 4'h2, 4'h2, 4'h3, 1'b1, 16'hBEEF);

    // JMP to 0x0200, then BRA 0xE0FE back to 0x01FF.
    drive(1'b1, 16'h0102, 16'hF008);
    tick();
    chk("jmp1.ev", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h0103, 16'h0200);
    tick();
    chk("jmp1.fv", {15'd0, fetch_valid_o}, 16'd1);
    chk("jmp1.fpc", fetch_pc_o, 16'h0200);
    chk("jmp1.ev2", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h0200, 16'hE0FE);
    tick();
    chk("bra.fv", {15'd0, fetch_valid_o}, 16'd1);
    chk("bra.fpc", fetch_pc_o, 16'h01FF);
    chk("bra.ev", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h0201, 16'h1230);
    tick();
    chk("stale.fv", {15'd0, fetch_valid_o}, 16'd0);
    chk("stale.ev", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h01FF, 16'h7890);
    tick();
    chk_exe("tgt", 16'h01FF, 4'h7, 4'h8, 4'h9, 1'b0, 16'h0000);

    // JMP to 0xFFFF, then JMP whose immediate word sits at 0x0000.
    drive(1'b1, 16'h0200, 16'hF008);
    tick();
    drive(1'b1, 16'h0201, 16'hFFFF);
    tick();
    chk("jmp2.fpc", fetch_pc_o, 16'hFFFF);
    drive(1'b1, 16'hFFFF, 16'hF008);
    tick();
    chk("wrap.ev0", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h0000, 16'h1234);
    tick();
    chk("wrap.fv", {15'd0, fetch_valid_o}, 16'd1);
    chk("wrap.fpc", fetch_pc_o, 16'h1234);
    chk("wrap.ev", {15'd0, exe_valid_o}, 16'd0);
    drive(1'b1, 16'h1234, 16'h3330);
    tick();
    chk_exe("wtgt", 16'h1234, 4'h3, 4'h3, 4'h3, 1'b0, 16'h0000);

    // Execute stalls three cycles; outputs hold and fetch is back-pressured.
    exe_ready_i = 1'b0;
    drive(1'b1, 16'h1235, 16'h5670);
    #1;
    chk("stall.frdy", {15'd0, fetch_ready_o}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_exe("stall", 16'h1234, 4'h3, 4'h3, 4'h3, 1'b0, 16'h0000);
      chk("stall.frdy_n", {15'd0, fetch_ready_o}, 16'd0);
    end
    exe_ready_i = 1'b1;
    #1;
    chk("rel.frdy", {15'd0, fetch_ready_o}, 16'd1);
    tick();
    chk_exe("reload", 16'h1235, 4'h5, 4'h6, 4'h7, 1'b0, 16'h0000);

    // JMP without IMM is forwarded like any other opcode.
    drive(1'b1, 16'h1236, 16'hF120);
    tick();
    chk_exe("jmpfwd", 16'h1236, 4'hF, 4'h1, 4'h2, 1'b0, 16'h0000);
    chk("jmpfwd.fv", {15'd0, fetch_valid_o}, 16'd0);

    // Reset while an opcode word is held; held word must be discarded.
    drive(1'b1, 16'h1237, 16'h2238);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    rstn = 1'b0;
    tick();
    chk_reset_state("rst3");
    rstn = 1'b1;
    drive(1'b1, 16'h0100, 16'h1230);
    tick();
    chk_exe("postrst", 16'h0100, 4'h1, 4'h2, 4'h3, 1'b0, 16'h0000);
    drive(1'b0, 16'h0, 16'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
